// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce
// Scans a 4x4 active-low matrix keypad one row at a time and debounces the
// result over whole scan frames. A key is accepted after DEBOUNCE_FRAMES
// identical single-key frames and released after DEBOUNCE_FRAMES empty frames.
// Acceptance produces a one-cycle 'pressed' strobe and updates enc_out.
module keypad_scan_debounce #(
  parameter int SCAN_DIV        = 1024,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [3:0] enc_out,
  output logic       pressed,
  output logic       key_held
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W  = $clog2(DEBOUNCE_FRAMES) + 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE            = 2'd0,
    PRESS_CONFIRM   = 2'd1,
    HELD            = 2'd2,
    RELEASE_CONFIRM = 2'd3
  } state_t;

  // Scan timing
  logic [SLOT_W-1:0] slot_reg;
  logic [1:0]        row_sel_reg;
  logic [3:0]        row_out_reg;
  logic              sample_edge;
  logic              frame_done;

  assign sample_edge = (slot_reg == SLOT_LAST);
  assign frame_done  = sample_edge && (row_sel_reg == 2'd3);

  // Slot counter and one-hot-low row rotation; the row advances on the sample edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_reg    <= '0;
      row_sel_reg <= 2'd0;
      row_out_reg <= 4'b1110;
    end else if (sample_edge) begin
      slot_reg    <= '0;
      row_sel_reg <= row_sel_reg + 2'd1;
      row_out_reg <= {row_out_reg[2:0], row_out_reg[3]};
    end else begin
      slot_reg    <= slot_reg + SLOT_W'(1);
    end
  end

  // Column decode: a low column means the key at (current row, column) is down.
  logic [3:0] col_low;
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      assign col_low[gi] = ~col_in[gi];
    end
  endgenerate

  // Number of closed keys in the current row and the lowest such column.
  logic [2:0] row_hits;
  logic [1:0] row_col;
  always_comb begin
    row_hits = 3'd0;
    row_col  = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (col_low[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = c[1:0];
      end
    end
  end

  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Frame accumulation: hits saturate at 2 (= MULTI); code is valid when hits==1.
  logic [1:0] hits_reg;
  logic [3:0] code_reg;
  logic [1:0] frame_hits;
  logic [3:0] frame_code;
  logic [3:0] hit_sum;

  // Merge the current row sample into the running frame result.
  always_comb begin
    hit_sum    = {2'b00, hits_reg} + {1'b0, row_hits};
    frame_hits = (hit_sum >= 4'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (hits_reg == 2'd0) ? key_code(row_sel_reg, row_col) : code_reg;
  end

  // Running frame result, cleared when the row-3 sample completes the frame.
  always_ff @(posedge clk) begin
    if (rst || frame_done) begin
      hits_reg <= 2'd0;
      code_reg <= 4'd0;
    end else if (sample_edge) begin
      hits_reg <= frame_hits;
      code_reg <= frame_code;
    end
  end

  logic frame_none;
  logic frame_single;
  assign frame_none   = (frame_hits == 2'd0);
  assign frame_single = (frame_hits == 2'd1);

  // Debounce FSM
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [3:0]       cand_reg, cand_next;
  logic [3:0]       enc_reg, enc_next;
  logic             pressed_reg, pressed_next;
  logic             held_reg, held_next;

  // Debounce state and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      cand_reg    <= 4'd0;
      enc_reg     <= 4'd0;
      pressed_reg <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      cand_reg    <= cand_next;
      enc_reg     <= enc_next;
      pressed_reg <= pressed_next;
      held_reg    <= held_next;
    end
  end

  // Next-state logic, evaluated only when a frame completes.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    cand_next    = cand_reg;
    enc_next     = enc_reg;
    held_next    = held_reg;
    pressed_next = 1'b0;
    cnt_inc      = (cnt_reg >= CNT_LIMIT) ? CNT_LIMIT : cnt_reg + CNT_ONE;
    if (frame_done) begin
      case (state_reg)
        IDLE: begin
          if (frame_single) begin
            state_next = PRESS_CONFIRM;
            cand_next  = frame_code;
            cnt_next   = CNT_ONE;
          end
        end
        PRESS_CONFIRM: begin
          if (frame_single && (frame_code == cand_reg)) begin
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_LIMIT) begin
              state_next   = HELD;
              enc_next     = cand_reg;
              pressed_next = 1'b1;
              held_next    = 1'b1;
            end
          end else if (frame_single) begin
            cand_next = frame_code;
            cnt_next  = CNT_ONE;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (frame_none) begin
            state_next = RELEASE_CONFIRM;
            cnt_next   = CNT_ONE;
          end
        end
        default: begin
          if (frame_none) begin
            cnt_next = cnt_inc;
            if (cnt_inc == CNT_LIMIT) begin
              state_next = IDLE;
              held_next  = 1'b0;
            end
          end else begin
            state_next = HELD;
          end
        end
      endcase
    end
  end

  assign row_out  = row_out_reg;
  assign enc_out  = enc_reg;
  assign pressed  = pressed_reg;
  assign key_held = held_reg;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Testbench for keypad_scan_debounce: models the key matrix, drives directed
// and random key patterns frame by frame, and compares against a frame-history
// model of the debounce rules.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV = 4;
  localparam int DF       = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [3:0] enc_out;
  logic       pressed;
  logic       key_held;

  logic [15:0] key_mask;   // bit r*4+c = key (r,c) is down

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         hist[$];     // last DF frame results: -1 none, -2 multi, else code
  logic       m_held;
  logic [3:0] m_enc;

  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] K2 = 16'h0002;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] K7 = 16'h0100;
  localparam logic [15:0] K9 = 16'h0400;
  localparam logic [15:0] KH = 16'h4000;  // '#'

  keypad_scan_debounce #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
    .enc_out(enc_out), .pressed(pressed), .key_held(key_held)
  );

  always #5 clk = ~clk;

  // Matrix: a column reads low while its row is driven low and the key is down.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_out[r] == 1'b0 && key_mask[r*4+c]) col_in[c] = 1'b0;
  end

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int classify(input logic [15:0] keys);
    int n = 0;
    int idx = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) begin n++; idx = i; end
    if (n == 0) return -1;
    if (n > 1) return -2;
    return int'(keymap[idx]);
  endfunction

  // One completed frame: accept after DF identical single frames while not
  // held; release after DF empty frames while held.
  task automatic model_frame(input logic [15:0] keys, output logic pulse);
    logic same = 1'b1;
    pulse = 1'b0;
    hist.push_back(classify(keys));
    if (hist.size() > DF) void'(hist.pop_front());
    if (hist.size() == DF) begin
      for (int i = 1; i < DF; i++) if (hist[i] != hist[0]) same = 1'b0;
      if (!m_held && same && hist[0] >= 0) begin
        m_held = 1'b1;
        m_enc  = 4'(hist[0]);
        pulse  = 1'b1;
      end else if (m_held && same && hist[0] == -1) begin
        m_held = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_held = 1'b0;
    m_enc  = 4'h0;
  endtask

  function automatic logic [3:0] exp_row(input int k);
    logic [3:0] one = 4'b0001;
    return ~(one << ((k / SCAN_DIV) % 4));
  endfunction

  // Runs n cycles of a frame with a fixed key set; n==FRAME completes it.
  task automatic run_cycles(input logic [15:0] keys, input int n, input string tag);
    logic ep;
    key_mask = keys;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      ep = 1'b0;
      if (k == FRAME) model_frame(keys, ep);
      check({tag, ".pressed"}, {3'b0, pressed}, {3'b0, ep});
      check({tag, ".key_held"}, {3'b0, key_held}, {3'b0, m_held});
      check({tag, ".enc_out"}, enc_out, m_enc);
      check({tag, ".row_out"}, row_out, exp_row(k));
    end
    $display("step %s keys=%h frames_or_cycles=%0d held=%b enc=%h", tag, keys, n, key_held, enc_out);
  endtask

  task automatic run_frames(input logic [15:0] keys, input int nf, input string tag);
    for (int f = 0; f < nf; f++) run_cycles(keys, FRAME, tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check({tag, ".rst_row"}, row_out, 4'b1110);
    check({tag, ".rst_enc"}, enc_out, 4'h0);
    check({tag, ".rst_pressed"}, {3'b0, pressed}, 4'h0);
    check({tag, ".rst_held"}, {3'b0, key_held}, 4'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("step %s reset applied", tag);
  endtask

  initial begin
    logic [15:0] rk;
    int kind, len, a, b;
    rst = 1'b1;
    key_mask = 16'h0;
    model_reset();

    // 1: reset, then row rotation checked every cycle
    do_reset("reset");
    run_frames(16'h0, 1, "idle");

    // 2: hold '5' -> single pulse at end of frame 3, none over 10 more frames
    run_frames(K5, 13, "hold5");
    run_frames(16'h0, 3, "rel5");

    // 3: bouncing '9'
    for (int i = 0; i < 8; i++) run_frames((i % 2 == 0) ? K9 : 16'h0, 1, "bounce9");
    run_frames(16'h0, 3, "quiet");

    // 4: '1'+'2' together, then '1' alone
    run_frames(K1 | K2, 2, "multi12");
    run_frames(K1, 3, "only1");
    run_frames(16'h0, 3, "rel1");

    // 5: '#' press, full release, press, short release
    run_frames(KH, 3, "hashA");
    run_frames(16'h0, 3, "hashRel3");
    run_frames(KH, 3, "hashB");
    run_frames(16'h0, 2, "hashRel2");
    run_frames(KH, 3, "hashC");
    run_frames(16'h0, 3, "hashRel");

    // 6: reset during HELD and during PRESS_CONFIRM
    run_frames(K5, 3, "held5");
    run_cycles(K5, 7, "held5part");
    do_reset("rstHeld");
    run_frames(K5, 3, "reacc5");
    run_frames(16'h0, 3, "rel5b");
    run_frames(K7, 1, "pc7");
    run_cycles(K7, 5, "pc7part");
    do_reset("rstPC");
    run_frames(K7, 3, "reacc7");
    run_frames(16'h0, 3, "rel7");

    // Random runs of none / single / double key frames
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 3);
      len  = $urandom_range(1, 5);
      a    = $urandom_range(0, 15);
      b    = (a + $urandom_range(1, 15)) % 16;
      rk   = 16'h0;
      if (kind == 1 || kind == 2) rk[a] = 1'b1;
      if (kind == 3) begin rk[a] = 1'b1; rk[b] = 1'b1; end
      run_frames(rk, len, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
